muxpga_cfg_loader: RTL and testbench

Upstream sequencer for the mux-FPGA fabric: accepts a configuration bitstream as bytes over a valid/ready handshake and drives the fabric's nibble/cmd/reset inputs. It clears the fabric, shifts the nibbles into the config chain, and re-shifts the stream while comparing the fabric's config readback. It then hands the fabric over to run mode. It keeps a shadow copy of the stream so the readback check needs no second upload.

---
 rtl/muxpga_pkg.sv | 22 ++
 rtl/muxpga_cfg_shadow.sv | 26 ++
 rtl/muxpga_cfg_loader.sv | 210 +++++++++++++++++++++
 tb/tb_muxpga_cfg_loader.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/muxpga_pkg.sv
// muxpga_pkg: fabric geometry, fabric cmd encodings and the
// configuration loader state type shared by the mux-FPGA blocks.
package muxpga_pkg;

    localparam int ROWS    = 4;
    localparam int COLS    = 4;
    localparam int CELLS   = (ROWS - 1) * COLS;
    localparam int NIBBLES = 2 * CELLS;

    localparam logic [1:0] CMD_SHIFT = 2'd0;
    localparam logic [1:0] CMD_RUN   = 2'd1;
    localparam logic [1:0] CMD_HOLD  = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_LOAD,
        ST_VERIFY,
        ST_RUN
    } ld_state_e;

endpackage

// File: rtl/muxpga_cfg_shadow.sv
// muxpga_cfg_shadow: NIBBLES x 4 register file holding the last shifted
// stream so the readback pass can replay it without a second upload.
module muxpga_cfg_shadow #(
    parameter int NIBBLES = muxpga_pkg::NIBBLES,
    parameter int IW      = $clog2(NIBBLES + 1)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [IW-1:0] widx_i,
    input  logic [3:0]    wdata_i,
    input  logic [IW-1:0] ridx_i,
    output logic [3:0]    rdata_o
);

    logic [3:0] mem_q [NIBBLES];

    // Capture each nibble as it goes out on the bus; content needs no reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[widx_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[ridx_i];

endmodule

// File: rtl/muxpga_cfg_loader.sv
// muxpga_cfg_loader: clears the fabric, shifts a byte stream into its
// config chain, re-shifts it against the readback, then enters run mode.
module muxpga_cfg_loader #(
    parameter int NIBBLES = muxpga_pkg::NIBBLES
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       run_en,
    input  logic [3:0] run_nibble,
    input  logic [7:0] fab_out,
    output logic [3:0] fab_nibble,
    output logic [1:0] fab_cmd,
    output logic       fab_reset,
    output logic       busy,
    output logic       done,
    output logic       err
);
    import muxpga_pkg::*;

    localparam int            CW   = $clog2(NIBBLES + 1);
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

    ld_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    byte_q, byte_d;
    logic          full_q, full_d;
    logic          phase_q, phase_d;
    logic [3:0]    nib_q, nib_d;
    logic [1:0]    cmd_q, cmd_d;
    logic          frst_q, frst_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          chk_q, chk_d;

    logic          clr;
    logic          accept;
    logic          shift;
    logic [3:0]    shift_nib;
    logic [3:0]    sh_rdata;
    logic          mism;
    logic          fab_out_unused;

    // Low bus half carries fabric data, not chain readback.
    assign fab_out_unused = ^fab_out[3:0];

    // Ready while the byte register is empty, or while its high nibble
    // leaves and more bytes are still owed to the chain.
    assign in_ready = (state_q == ST_LOAD)
                   && (!full_q || (phase_q && (cnt_q != LAST)));
    assign accept   = in_valid && in_ready;

    // The bus nibble is the replayed shadow entry; the chain tail must match.
    assign mism = chk_q && (fab_out[7:4] != nib_q);

    muxpga_cfg_shadow #(
        .NIBBLES (NIBBLES),
        .IW      (CW)
    ) u_shadow (
        .clk     (clk),
        .we_i    (shift),
        .widx_i  (cnt_q),
        .wdata_i (shift_nib),
        .ridx_i  (cnt_q),
        .rdata_o (sh_rdata)
    );

    // Next state plus the registered fabric drive decided alongside it.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        byte_d    = byte_q;
        full_d    = full_q;
        phase_d   = phase_q;
        nib_d     = nib_q;
        cmd_d     = CMD_HOLD;
        frst_d    = 1'b0;
        done_d    = done_q;
        chk_d     = 1'b0;
        clr       = 1'b0;
        shift     = 1'b0;
        shift_nib = 4'h0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_CLEAR;
                    frst_d  = 1'b1;
                    done_d  = 1'b0;
                    clr     = 1'b1;
                end
            end
            ST_CLEAR: begin
                state_d = ST_LOAD;
                cnt_d   = '0;
                full_d  = 1'b0;
                phase_d = 1'b0;
            end
            ST_LOAD: begin
                if (!full_q) begin
                    // Empty: a fresh byte's low nibble goes out at once.
                    if (accept) begin
                        shift     = 1'b1;
                        shift_nib = in_data[3:0];
                        byte_d    = in_data;
                        full_d    = 1'b1;
                        phase_d   = 1'b1;
                    end
                end else if (!phase_q) begin
                    shift     = 1'b1;
                    shift_nib = byte_q[3:0];
                    phase_d   = 1'b1;
                end else begin
                    shift     = 1'b1;
                    shift_nib = byte_q[7:4];
                    if (accept) begin
                        byte_d  = in_data;
                        phase_d = 1'b0;
                    end else begin
                        full_d  = 1'b0;
                    end
                end
                if (shift) begin
                    cmd_d = CMD_SHIFT;
                    nib_d = shift_nib;
                    if (cnt_q == LAST) begin
                        state_d = ST_VERIFY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q + CW'(1);
                    end
                end
            end
            ST_VERIFY: begin
                cmd_d = CMD_SHIFT;
                nib_d = sh_rdata;
                chk_d = 1'b1;
                if (cnt_q == LAST) begin
                    state_d = ST_RUN;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            ST_RUN: begin
                if (start) begin
                    state_d = ST_CLEAR;
                    frst_d  = 1'b1;
                    done_d  = 1'b0;
                    clr     = 1'b1;
                end else begin
                    cmd_d = run_en ? CMD_RUN : CMD_HOLD;
                    nib_d = run_nibble;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_CLEAR)
              || (state_d == ST_LOAD)
              || (state_d == ST_VERIFY);
        err_d  = clr ? 1'b0 : (err_q | mism);
    end

    // State, byte splitter and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            byte_q  <= 8'h00;
            full_q  <= 1'b0;
            phase_q <= 1'b0;
            nib_q   <= 4'h0;
            cmd_q   <= CMD_HOLD;
            frst_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            chk_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            byte_q  <= byte_d;
            full_q  <= full_d;
            phase_q <= phase_d;
            nib_q   <= nib_d;
            cmd_q   <= cmd_d;
            frst_q  <= frst_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            chk_q   <= chk_d;
        end
    end

    assign fab_nibble = nib_q;
    assign fab_cmd    = cmd_q;
    assign fab_reset  = frst_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_muxpga_cfg_loader.sv
// tb_muxpga_cfg_loader: drives byte loads into the loader against a
// shift-chain fabric model and scoreboards every nibble on the bus.
module tb_muxpga_cfg_loader;
    import muxpga_pkg::*;

    localparam int N  = NIBBLES;
    localparam int NB = N / 2;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       run_en;
    logic [3:0] run_nibble;
    logic [7:0] fab_out;
    logic [3:0] fab_nibble;
    logic [1:0] fab_cmd;
    logic       fab_reset;
    logic       busy;
    logic       done;
    logic       err;

    always #5 clk = ~clk;

    muxpga_cfg_loader #(.NIBBLES(N)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .run_en     (run_en),
        .run_nibble (run_nibble),
        .fab_out    (fab_out),
        .fab_nibble (fab_nibble),
        .fab_cmd    (fab_cmd),
        .fab_reset  (fab_reset),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [3:0] exp_q [$];
    logic [3:0] mon_e;

    logic [3:0] chain [N] = '{default: 4'h0};
    int         nshift = 0;
    bit         flip_en = 1'b0;
    logic       flip_hit;

    logic [7:0] bytes [NB];
    logic [3:0] stream [N];

    always @(posedge clk) cyc <= cyc + 1;

    // Fabric: synchronous clear, shift chain with the tail on fab_out[7:4].
    always @(posedge clk) begin
        if (fab_reset) begin
            for (int i = 0; i < N; i++) chain[i] <= 4'h0;
            nshift <= 0;
        end else if (fab_cmd == CMD_SHIFT) begin
            chain[0] <= fab_nibble;
            for (int i = 1; i < N; i++) chain[i] <= chain[i-1];
            nshift <= nshift + 1;
        end
    end

    assign flip_hit = flip_en && (nshift == N + 5) && (fab_cmd == CMD_SHIFT);
    assign fab_out  = {chain[N-1] ^ {3'b000, flip_hit}, 4'h0};

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every shift on the bus must be the next expected nibble.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && fab_cmd == CMD_SHIFT) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL shift_unexpected: got 0x%0h, required none",
                         fab_nibble);
            end else begin
                mon_e = exp_q.pop_front();
                chk("shift_nibble", {28'd0, fab_nibble}, {28'd0, mon_e});
            end
        end
    end

    function automatic void build_stream();
        for (int b = 0; b < NB; b++) begin
            stream[2*b]   = bytes[b][3:0];
            stream[2*b+1] = bytes[b][7:4];
        end
    endfunction

    // gap_mode: 0 = valid always, 1 = alternate cycles, 2 = random.
    task automatic do_load(input int gap_mode, input bit mid_start,
                           input int max_bytes, input bit exp_err);
        int bi;
        int iter;
        int t0;
        int guard;
        int mism;
        bit acc;
        build_stream();
        @(posedge clk); #1;
        start    = 1'b1;
        in_valid = (gap_mode == 0);
        in_data  = bytes[0];
        t0       = cyc + 1;
        @(negedge clk);
        chk("in_ready_idle", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("clear_fab_reset", {31'd0, fab_reset}, 32'd1);
        chk("clear_busy", {31'd0, busy}, 32'd1);
        chk("clear_done", {31'd0, done}, 32'd0);
        chk("clear_err", {31'd0, err}, 32'd0);
        @(posedge clk); #1;
        bi   = 0;
        iter = 0;
        while (bi < max_bytes && iter < 400) begin
            in_data = bytes[bi];
            if (gap_mode == 0)      in_valid = 1'b1;
            else if (gap_mode == 1) in_valid = iter[0];
            else                    in_valid = ($urandom_range(0, 2) == 0);
            start = mid_start && (iter == 7);
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) begin
                exp_q.push_back(bytes[bi][3:0]);
                exp_q.push_back(bytes[bi][7:4]);
                bi++;
                if (bi == NB) begin
                    for (int i = 0; i < N; i++) exp_q.push_back(stream[i]);
                end
            end
            iter++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        if (bi < max_bytes) chk("feed_timeout", bi, max_bytes);
        if (max_bytes < NB) return;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!done && guard < 300);
        chk("done", {31'd0, done}, 32'd1);
        if (gap_mode == 0) chk("load_cycles", cyc - t0, 49);
        repeat (2) @(negedge clk);
        chk("err", {31'd0, err}, {31'd0, exp_err});
        chk("done_hold", {31'd0, done}, 32'd1);
        chk("busy_run", {31'd0, busy}, 32'd0);
        chk("exp_drained", exp_q.size(), 0);
        mism = 0;
        for (int i = 0; i < N; i++) begin
            if (chain[N-1-i] !== stream[i]) mism++;
        end
        chk("chain_content", mism, 0);
    endtask

    task automatic set_directed();
        logic [7:0] seq [NB];
        seq = '{8'h10, 8'h32, 8'h54, 8'h76, 8'h98, 8'hBA,
                8'hDC, 8'hFE, 8'h10, 8'h32, 8'h54, 8'h76};
        for (int i = 0; i < NB; i++) bytes[i] = seq[i];
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_cmd"}, {30'd0, fab_cmd}, 32'd2);
        chk({tag, "_fab_reset"}, {31'd0, fab_reset}, 32'd1);
        chk({tag, "_nibble"}, {28'd0, fab_nibble}, 32'd0);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_err"}, {31'd0, err}, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_n    = 1'b0;
        start      = 1'b0;
        in_data    = 8'h00;
        in_valid   = 1'b0;
        run_en     = 1'b0;
        run_nibble = 4'h0;

        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_release_fab_reset", {31'd0, fab_reset}, 32'd0);

        set_directed();
        do_load(0, 1'b0, NB, 1'b0);

        @(posedge clk); #1;
        run_en     = 1'b1;
        run_nibble = 4'hA;
        @(negedge clk);
        chk("run_cmd_before_edge", {30'd0, fab_cmd}, 32'd2);
        @(negedge clk);
        chk("run_cmd", {30'd0, fab_cmd}, 32'd1);
        chk("run_nibble", {28'd0, fab_nibble}, 32'hA);
        @(posedge clk); #1;
        run_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("hold_cmd", {30'd0, fab_cmd}, 32'd2);

        do_load(1, 1'b0, NB, 1'b0);

        flip_en = 1'b1;
        do_load(0, 1'b0, NB, 1'b1);
        flip_en = 1'b0;
        do_load(0, 1'b1, NB, 1'b0);

        do_load(0, 1'b0, 5, 1'b0);
        reset_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        do_load(0, 1'b0, NB, 1'b0);

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < NB; i++) bytes[i] = 8'($urandom);
            do_load(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                    NB, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
